key_search: RTL and testbench

- Brute-force key-search controller that sits directly upstream of the arc4 decryption engine.
- Drives the arc4 key and its en/rdy handshake, and resets arc4 between trials, because arc4 runs only once per reset.
- After each decryption it reads back the plaintext memory and checks that every message byte is printable ASCII.
- Reports the first key in its range that passes, or reports failure when the range is exhausted or the search is aborted.

---
 rtl/arc4_pkg.sv | 23 ++
 rtl/printable_chk.sv | 12 +
 rtl/key_search.sv | 156 +++++++++++++++
 tb/tb_key_search.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/arc4_pkg.sv
// rtl/arc4_pkg.sv - shared types and constants for the arc4 key-search slice
// Printable-ASCII bounds, key type and the key_search state encoding.
package arc4_pkg;

  typedef logic [23:0] key_t;

  localparam logic [7:0] ASCII_MIN = 8'h20;
  localparam logic [7:0] ASCII_MAX = 8'h7E;

  typedef enum logic [3:0] {
    S_IDLE  = 4'd0,
    S_RST4  = 4'd1,
    S_START = 4'd2,
    S_WBUSY = 4'd3,
    S_WDONE = 4'd4,
    S_RLEN  = 4'd5,
    S_CHK   = 4'd6,
    S_NEXT  = 4'd7,
    S_FOUND = 4'd8,
    S_FAIL  = 4'd9
  } ks_state_t;

endpackage

// File: rtl/printable_chk.sv
// rtl/printable_chk.sv - combinational printable-ASCII range check
// pass is high when ASCII_MIN <= data <= ASCII_MAX.
module printable_chk
  import arc4_pkg::*;
(
  input  logic [7:0] data,
  output logic       pass
);

  assign pass = (data >= ASCII_MIN) && (data <= ASCII_MAX);

endmodule

// File: rtl/key_search.sv
// rtl/key_search.sv - brute-force key-search controller upstream of arc4
// Resets and runs arc4 once per trial key, then scans the plaintext for printable bytes.
module key_search
  import arc4_pkg::*;
#(
  parameter key_t KEY_START = 24'h000000,
  parameter key_t KEY_STEP  = 24'h000001,
  parameter key_t KEY_LAST  = 24'hFFFFFF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic       abort,
  output logic       rdy,
  output key_t       key,
  output logic       key_valid,
  output logic       arc4_rst_n,
  output logic       arc4_en,
  input  logic       arc4_rdy,
  output key_t       arc4_key,
  output logic       pt_sel,
  output logic [7:0] pt_addr,
  input  logic [7:0] pt_rddata
);

  ks_state_t   state;
  logic [7:0]  len;
  logic [7:0]  rd_idx;
  logic        rd_vld;
  logic        byte_ok;
  logic [24:0] next_key;
  logic        exhausted;

  printable_chk u_chk (
    .data (pt_rddata),
    .pass (byte_ok)
  );

  // 25-bit sum so a step past 24'hFFFFFF counts as exhausted instead of wrapping.
  assign next_key  = {1'b0, arc4_key} + {1'b0, KEY_STEP};
  assign exhausted = next_key > {1'b0, KEY_LAST};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      rdy        <= 1'b1;
      key        <= '0;
      key_valid  <= 1'b0;
      arc4_rst_n <= 1'b0;
      arc4_en    <= 1'b0;
      arc4_key   <= KEY_START;
      pt_sel     <= 1'b0;
      pt_addr    <= '0;
      len        <= '0;
      rd_idx     <= '0;
      rd_vld     <= 1'b0;
    end else if (abort && state != S_IDLE) begin
      // Leave arc4 freshly reset so the next search starts from a clean engine.
      state      <= S_IDLE;
      rdy        <= 1'b1;
      key_valid  <= 1'b0;
      arc4_en    <= 1'b0;
      arc4_rst_n <= 1'b0;
      pt_sel     <= 1'b0;
      pt_addr    <= '0;
      rd_vld     <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          arc4_rst_n <= 1'b1;
          if (en && !abort) begin
            arc4_key   <= KEY_START;
            key_valid  <= 1'b0;
            rdy        <= 1'b0;
            arc4_rst_n <= 1'b0;
            state      <= S_RST4;
          end
        end
        S_RST4: begin
          arc4_rst_n <= 1'b1;
          state      <= S_START;
        end
        S_START: begin
          if (arc4_rdy) begin
            arc4_en <= 1'b1;
            state   <= S_WBUSY;
          end
        end
        S_WBUSY: begin
          arc4_en <= 1'b0;
          if (!arc4_rdy) state <= S_WDONE;
        end
        S_WDONE: begin
          if (arc4_rdy) begin
            pt_sel  <= 1'b1;
            pt_addr <= '0;
            rd_vld  <= 1'b0;
            state   <= S_RLEN;
          end
        end
        S_RLEN: begin
          // rd_vld marks the second cycle, when the length byte is on pt_rddata.
          if (!rd_vld) begin
            rd_vld <= 1'b1;
          end else begin
            len    <= pt_rddata;
            rd_vld <= 1'b0;
            if (pt_rddata == 8'd0) begin
              state <= S_FOUND;
            end else begin
              pt_addr <= 8'd1;
              state   <= S_CHK;
            end
          end
        end
        S_CHK: begin
          // Reads stay one address ahead of the byte being checked; stop issuing at len.
          if (pt_addr != len) pt_addr <= pt_addr + 8'd1;
          rd_idx <= pt_addr;
          rd_vld <= 1'b1;
          if (rd_vld) begin
            if (!byte_ok) state <= S_NEXT;
            else if (rd_idx == len) state <= S_FOUND;
          end
        end
        S_NEXT: begin
          pt_sel  <= 1'b0;
          pt_addr <= '0;
          rd_vld  <= 1'b0;
          if (exhausted) begin
            state <= S_FAIL;
          end else begin
            arc4_key   <= next_key[23:0];
            arc4_rst_n <= 1'b0;
            state      <= S_RST4;
          end
        end
        S_FOUND: begin
          key       <= arc4_key;
          key_valid <= 1'b1;
          rdy       <= 1'b1;
          pt_sel    <= 1'b0;
          pt_addr   <= '0;
          state     <= S_IDLE;
        end
        S_FAIL: begin
          key_valid <= 1'b0;
          rdy       <= 1'b1;
          state     <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_key_search.sv
// tb/tb_key_search.sv - directed bench for key_search with a behavioural arc4 and pt memory
// Three instances cover the default range, a short range and an odd-key split.
`timescale 1ns/1ps
module tb_key_search;
  import arc4_pkg::*;

  localparam int N       = 3;
  localparam int ARC_CYC = 3;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic       en_s [N];
  logic       abort_s [N];
  logic       rdy_s [N];
  logic       kv_s [N];
  logic       a_rst_n [N];
  logic       a_en [N];
  logic       a_rdy [N];
  logic       pt_sel_s [N];
  key_t       key_s [N];
  key_t       a_key [N];
  key_t       dec_key [N];
  key_t       good_key [N];
  key_t       max_key [N];
  logic [7:0] pt_addr_s [N];
  logic [7:0] pt_rd [N];
  logic [7:0] max_addr [N];
  logic [3:0] a_cnt [N];
  int         pt_mode [N];
  int         trials [N];
  int         rst_lows [N];
  logic       clr_mon;
  int         total = 0;
  int         bad = 0;

  key_search #(.KEY_START(24'h000000), .KEY_STEP(24'h000001), .KEY_LAST(24'hFFFFFF)) u0 (
    .clk(clk), .rst_n(rst_n), .en(en_s[0]), .abort(abort_s[0]), .rdy(rdy_s[0]),
    .key(key_s[0]), .key_valid(kv_s[0]), .arc4_rst_n(a_rst_n[0]), .arc4_en(a_en[0]),
    .arc4_rdy(a_rdy[0]), .arc4_key(a_key[0]), .pt_sel(pt_sel_s[0]),
    .pt_addr(pt_addr_s[0]), .pt_rddata(pt_rd[0])
  );

  key_search #(.KEY_START(24'h000000), .KEY_STEP(24'h000001), .KEY_LAST(24'h000003)) u1 (
    .clk(clk), .rst_n(rst_n), .en(en_s[1]), .abort(abort_s[1]), .rdy(rdy_s[1]),
    .key(key_s[1]), .key_valid(kv_s[1]), .arc4_rst_n(a_rst_n[1]), .arc4_en(a_en[1]),
    .arc4_rdy(a_rdy[1]), .arc4_key(a_key[1]), .pt_sel(pt_sel_s[1]),
    .pt_addr(pt_addr_s[1]), .pt_rddata(pt_rd[1])
  );

  key_search #(.KEY_START(24'h000001), .KEY_STEP(24'h000002), .KEY_LAST(24'h000009)) u2 (
    .clk(clk), .rst_n(rst_n), .en(en_s[2]), .abort(abort_s[2]), .rdy(rdy_s[2]),
    .key(key_s[2]), .key_valid(kv_s[2]), .arc4_rst_n(a_rst_n[2]), .arc4_en(a_en[2]),
    .arc4_rdy(a_rdy[2]), .arc4_key(a_key[2]), .pt_sel(pt_sel_s[2]),
    .pt_addr(pt_addr_s[2]), .pt_rddata(pt_rd[2])
  );

  // Plaintext seen after decrypting with key k; mode picks the scenario.
  function automatic logic [7:0] pt_byte(input int mode, input key_t k, input key_t good,
                                         input logic [7:0] a);
    case (mode)
      1: begin
        if (k == 24'h0 && a == 8'd0) return 8'h00;
        return (a == 8'd0) ? 8'h03 : 8'h07;
      end
      2, 3: begin
        if (a == 8'd0) return 8'hFF;
        if (a == 8'd1) return 8'h20;
        if (a == 8'd255) return (mode == 3 && k == 24'h0) ? 8'h7F : 8'h7E;
        return 8'h7E;
      end
      default: begin
        if (k == good) begin
          case (a)
            8'd0:    return 8'h03;
            8'd1:    return 8'h48;
            8'd2:    return 8'h69;
            8'd3:    return 8'h21;
            default: return 8'h00;
          endcase
        end
        return (a == 8'd0) ? 8'h03 : 8'h07;
      end
    endcase
  endfunction

  always @(posedge clk) begin
    for (int g = 0; g < N; g++) begin
      if (!a_rst_n[g]) begin
        a_rdy[g] <= 1'b1;
        a_cnt[g] <= '0;
      end else if (a_rdy[g] && a_en[g]) begin
        a_rdy[g]   <= 1'b0;
        a_cnt[g]   <= 4'(ARC_CYC);
        dec_key[g] <= a_key[g];
      end else if (!a_rdy[g]) begin
        if (a_cnt[g] == 4'd0) a_rdy[g] <= 1'b1;
        else a_cnt[g] <= a_cnt[g] - 4'd1;
      end
      pt_rd[g] <= pt_byte(pt_mode[g], dec_key[g], good_key[g], pt_addr_s[g]);
      if (clr_mon) begin
        trials[g]   <= 0;
        rst_lows[g] <= 0;
        max_key[g]  <= a_key[g];
        max_addr[g] <= pt_addr_s[g];
      end else begin
        if (a_en[g]) trials[g] <= trials[g] + 1;
        if (!a_rst_n[g]) rst_lows[g] <= rst_lows[g] + 1;
        if (a_key[g] > max_key[g]) max_key[g] <= a_key[g];
        if (pt_addr_s[g] > max_addr[g]) max_addr[g] <= pt_addr_s[g];
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic clr();
    @(negedge clk) clr_mon = 1'b1;
    @(negedge clk) clr_mon = 1'b0;
  endtask

  task automatic run(input int g, input string tag);
    bit done;
    @(negedge clk) en_s[g] = 1'b1;
    @(negedge clk) en_s[g] = 1'b0;
    done = 1'b0;
    for (int i = 0; i < 3000 && !done; i++) begin
      @(negedge clk);
      if (rdy_s[g]) done = 1'b1;
    end
    check({tag, "_done"}, 32'(done), 32'd1);
  endtask

  initial begin
    bit hit;
    rst_n   = 1'b0;
    clr_mon = 1'b0;
    for (int g = 0; g < N; g++) begin
      en_s[g]    = 1'b0;
      abort_s[g] = 1'b0;
      pt_mode[g] = 0;
    end
    good_key[0] = 24'h000005;
    good_key[1] = 24'hFFFFFF;
    good_key[2] = 24'h000004;

    #22;
    check("rst_rdy", 32'(rdy_s[0]), 32'd1);
    check("rst_kv", 32'(kv_s[0]), 32'd0);
    check("rst_key", 32'(key_s[0]), 32'd0);
    check("rst_a_rst_n", 32'(a_rst_n[0]), 32'd0);
    check("rst_a_en", 32'(a_en[0]), 32'd0);
    check("rst_pt_sel", 32'(pt_sel_s[0]), 32'd0);
    check("rst_pt_addr", 32'(pt_addr_s[0]), 32'd0);
    check("rst_a_key2", 32'(a_key[2]), 32'd1);

    @(negedge clk) rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("idle_a_rst_n", 32'(a_rst_n[0]), 32'd1);

    // Key 5 is the only printable one: six trials, six arc4 reset pulses.
    clr();
    run(0, "t1");
    check("t1_key", 32'(key_s[0]), 32'h5);
    check("t1_kv", 32'(kv_s[0]), 32'd1);
    check("t1_trials", 32'(trials[0]), 32'd6);
    check("t1_rst_lows", 32'(rst_lows[0]), 32'd6);

    clr();
    run(1, "t2");
    check("t2_kv", 32'(kv_s[1]), 32'd0);
    check("t2_trials", 32'(trials[1]), 32'd4);
    check("t2_max_key", 32'(max_key[1]), 32'h3);

    // Odd keys only: 1,3,5,7,9 skip the printable key 4.
    clr();
    run(2, "t3a");
    check("t3a_kv", 32'(kv_s[2]), 32'd0);
    check("t3a_trials", 32'(trials[2]), 32'd5);
    check("t3a_max_key", 32'(max_key[2]), 32'h9);
    good_key[2] = 24'h000007;
    clr();
    run(2, "t3b");
    check("t3b_key", 32'(key_s[2]), 32'h7);
    check("t3b_kv", 32'(kv_s[2]), 32'd1);
    check("t3b_trials", 32'(trials[2]), 32'd4);

    pt_mode[0] = 1;
    clr();
    run(0, "t4");
    check("t4_key", 32'(key_s[0]), 32'h0);
    check("t4_kv", 32'(kv_s[0]), 32'd1);
    check("t4_trials", 32'(trials[0]), 32'd1);
    check("t4_max_addr", 32'(max_addr[0]), 32'd0);

    pt_mode[0] = 2;
    clr();
    run(0, "t5a");
    check("t5a_key", 32'(key_s[0]), 32'h0);
    check("t5a_kv", 32'(kv_s[0]), 32'd1);
    check("t5a_max_addr", 32'(max_addr[0]), 32'hFF);
    pt_mode[0] = 3;
    clr();
    run(0, "t5b");
    check("t5b_key", 32'(key_s[0]), 32'h1);
    check("t5b_kv", 32'(kv_s[0]), 32'd1);
    check("t5b_trials", 32'(trials[0]), 32'd2);

    // Abort while arc4 is still busy on the second trial.
    pt_mode[0] = 0;
    clr();
    @(negedge clk) en_s[0] = 1'b1;
    @(negedge clk) en_s[0] = 1'b0;
    hit = 1'b0;
    for (int i = 0; i < 500 && !hit; i++) begin
      @(negedge clk);
      if (trials[0] == 2 && !a_rdy[0]) hit = 1'b1;
    end
    check("t6_reach", 32'(hit), 32'd1);
    @(negedge clk) clr_mon = 1'b1;
    @(negedge clk) begin
      clr_mon    = 1'b0;
      abort_s[0] = 1'b1;
    end
    @(negedge clk) abort_s[0] = 1'b0;
    check("t6_rdy", 32'(rdy_s[0]), 32'd1);
    check("t6_kv", 32'(kv_s[0]), 32'd0);
    check("t6_a_en", 32'(a_en[0]), 32'd0);
    check("t6_pt_sel", 32'(pt_sel_s[0]), 32'd0);
    check("t6_a_rst_n", 32'(a_rst_n[0]), 32'd0);
    repeat (4) @(negedge clk);
    check("t6_rst_lows", 32'(rst_lows[0]), 32'd1);
    check("t6_trials", 32'(trials[0]), 32'd0);
    check("t6_rdy_hold", 32'(rdy_s[0]), 32'd1);

    // abort together with en in idle: nothing starts.
    clr();
    @(negedge clk) begin
      en_s[0]    = 1'b1;
      abort_s[0] = 1'b1;
    end
    @(negedge clk) begin
      en_s[0]    = 1'b0;
      abort_s[0] = 1'b0;
    end
    check("t7_rdy", 32'(rdy_s[0]), 32'd1);
    repeat (3) @(negedge clk);
    check("t7_trials", 32'(trials[0]), 32'd0);
    check("t7_rst_lows", 32'(rst_lows[0]), 32'd0);

    // Asynchronous reset in the middle of a long plaintext scan.
    pt_mode[0] = 2;
    @(negedge clk) en_s[0] = 1'b1;
    @(negedge clk) en_s[0] = 1'b0;
    hit = 1'b0;
    for (int i = 0; i < 500 && !hit; i++) begin
      @(negedge clk);
      if (pt_sel_s[0] && pt_addr_s[0] > 8'd10) hit = 1'b1;
    end
    check("t8_reach", 32'(hit), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("t8_rdy", 32'(rdy_s[0]), 32'd1);
    check("t8_kv", 32'(kv_s[0]), 32'd0);
    check("t8_key", 32'(key_s[0]), 32'd0);
    check("t8_a_rst_n", 32'(a_rst_n[0]), 32'd0);
    check("t8_a_key", 32'(a_key[0]), 32'd0);
    check("t8_pt_sel", 32'(pt_sel_s[0]), 32'd0);
    check("t8_pt_addr", 32'(pt_addr_s[0]), 32'd0);
    @(negedge clk) rst_n = 1'b1;
    repeat (2) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
